// File: rtl/ps2_kbd_pkg.sv
// Shared constants and receive-FSM encoding for the PS/2 keyboard receiver.
package ps2_kbd_pkg;

    localparam int KbWidth = 8;

    // Bit-counter value of the stop bit: 8 data bits (0..7), parity (8), stop (9).
    localparam logic [3:0] StopIdx = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rxState_e;

endpackage

// File: rtl/ps2_kbd_if.sv
// Host-side scan-code read port of the PS/2 keyboard receiver.
interface ps2_kbd_if;
    import ps2_kbd_pkg::*;

    logic               kb_rd;
    logic [KbWidth-1:0] kb_rdata;
    logic               kb_ready;
    logic               overflow;

    modport master (output kb_rd, input kb_rdata, input kb_ready, input overflow);
    modport slave  (input kb_rd, output kb_rdata, output kb_ready, output overflow);

endinterface

// File: rtl/kbd_fifo.sv
// Scan-code FIFO: power-of-two depth, combinational head, push-while-full legal with a pop.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AddrWidth = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AddrWidth-1:0] wrPtr;
    logic [AddrWidth-1:0] rdPtr;
    logic [AddrWidth:0]   count;
    logic                 doPush;
    logic                 doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AddrWidth+1)'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr];

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizers, frame FSM, watchdog and scan-code FIFO.
// Define KBD_PARITY_CHK_EN to reject frames with bad odd parity; otherwise only the stop bit counts.
module ps2_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ps2_clk,
    input  logic      ps2_data,
    ps2_kbd_if.slave  kb
);

    localparam int WdWidth = $clog2(TIMEOUT + 1);

    logic [2:0]         clkSync;
    logic [2:0]         dataSync;
    logic               fallEdge;
    logic               bitIn;

    rxState_e           state, stateNext;
    logic [3:0]         bitCnt, bitCntNext;
    logic [9:0]         shiftReg, shiftNext;
    logic [WdWidth-1:0] wdog, wdogNext;
    logic               frameOk;
    logic               pushReq;
    logic               popReq;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               overflowReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync  <= '1;
            dataSync <= '1;
        end else begin
            clkSync  <= {clkSync[1:0], ps2_clk};
            dataSync <= {dataSync[1:0], ps2_data};
        end
    end

    // Data is taken from the stage aligned with the older half of the edge detector.
    assign fallEdge = (clkSync[2:1] == 2'b10);
    assign bitIn    = dataSync[2];

    // shiftReg fills LSB-first so that after the stop edge: [7:0]=data, [8]=parity, [9]=stop.
`ifdef KBD_PARITY_CHK_EN
    assign frameOk = shiftReg[9] && (^shiftReg[8:0]);
`else
    assign frameOk = shiftReg[9];
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        wdogNext   = '0;
        pushReq    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fallEdge && !bitIn) begin
                    stateNext  = SHIFT;
                    bitCntNext = '0;
                end
            end
            SHIFT: begin
                if (fallEdge) begin
                    shiftNext  = {bitIn, shiftReg[9:1]};
                    bitCntNext = bitCnt + 1'b1;
                    if (bitCnt == StopIdx) stateNext = CHECK;
                end else if (wdog == WdWidth'(TIMEOUT)) begin
                    stateNext = IDLE;
                end else begin
                    wdogNext = wdog + 1'b1;
                end
            end
            CHECK: begin
                stateNext = IDLE;
                pushReq   = frameOk;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitCnt      <= '0;
            shiftReg    <= '0;
            wdog        <= '0;
            overflowReg <= 1'b0;
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            wdog     <= wdogNext;
            // A simultaneous pop makes room, so a full FIFO only loses data without one.
            if (pushReq && fifoFull && !popReq) overflowReg <= 1'b1;
        end
    end

    assign popReq = kb.kb_rd && !fifoEmpty;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KbWidth)
    ) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushReq),
        .pop   (popReq),
        .din   (shiftReg[7:0]),
        .dout  (kb.kb_rdata),
        .empty (fifoEmpty),
        .full  (fifoFull)
    );

    assign kb.kb_ready = !fifoEmpty;
    assign kb.overflow = overflowReg;

endmodule
